// File: rtl/door_controller_if.sv
// Request/status bundle between the floor/motion controller and the door sequencer.
// The master side drives requests and sensing; the slave side (door controller) reports state.
interface door_controller_if;
  logic       tick;
  logic       open_req;
  logic       close_req;
  logic       obstruct;
  logic       moving;
  logic [1:0] door_state;
  logic       door_closed;
  logic       opened;
  logic       done;

  modport master (
    output tick, open_req, close_req, obstruct, moving,
    input  door_state, door_closed, opened, done
  );

  modport slave (
    input  tick, open_req, close_req, obstruct, moving,
    output door_state, door_closed, opened, done
  );
endinterface

// File: rtl/door_controller.sv
// Elevator car door sequencer: times opening, dwell and closing in whole divider ticks,
// with obstruction/re-open handling and a car-moving interlock on opening from closed.
module door_controller #(
  parameter int unsigned OPEN_TICKS  = 4,
  parameter int unsigned HOLD_TICKS  = 30,
  parameter int unsigned CLOSE_TICKS = 4
) (
  input logic              clk,
  input logic              reset,
  door_controller_if.slave dbus
);

  localparam int unsigned MaxOc    = (OPEN_TICKS > CLOSE_TICKS) ? OPEN_TICKS : CLOSE_TICKS;
  localparam int unsigned MaxTicks = (HOLD_TICKS > MaxOc) ? HOLD_TICKS : MaxOc;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);

  localparam logic [CntW-1:0] OpenLast  = CntW'(OPEN_TICKS - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_TICKS - 1);
  localparam logic [CntW-1:0] CloseLast = CntW'(CLOSE_TICKS - 1);

  typedef enum logic [1:0] {
    StClosed  = 2'd0,
    StOpening = 2'd1,
    StOpen    = 2'd2,
    StClosing = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            door_closed_q;
  logic            opened_q, opened_d;
  logic            done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opened_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StClosed: begin
        if (dbus.open_req && !dbus.moving) begin
          state_d = StOpening;
          cnt_d   = '0;
        end
      end

      StOpening: begin
        if (dbus.tick) begin
          if (cnt_q == OpenLast) begin
            state_d  = StOpen;
            cnt_d    = '0;
            opened_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StOpen: begin
        // Obstruction and open_req both pin the dwell at its start.
        if (dbus.obstruct || dbus.open_req) begin
          cnt_d = '0;
        end else if (dbus.close_req) begin
          state_d = StClosing;
          cnt_d   = '0;
        end else if (dbus.tick) begin
          if (cnt_q == HoldLast) begin
            state_d = StClosing;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StClosing: begin
        // Reopen wins over a coincident tick.
        if (dbus.obstruct || dbus.open_req) begin
          state_d = StOpening;
          cnt_d   = '0;
        end else if (dbus.tick) begin
          if (cnt_q == CloseLast) begin
            state_d = StClosed;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      default: begin
        state_d = StClosed;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StClosed;
      cnt_q         <= '0;
      door_closed_q <= 1'b1;
      opened_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      door_closed_q <= (state_d == StClosed);
      opened_q      <= opened_d;
      done_q        <= done_d;
    end
  end

  assign dbus.door_state  = state_q;
  assign dbus.door_closed = door_closed_q;
  assign dbus.opened      = opened_q;
  assign dbus.done        = done_q;

endmodule

// File: tb/tb_door_controller.sv
// Bench for door_controller: default-parameter and all-ones instances driven in lockstep,
// checked every clk against a remaining-ticks behavioural model.
module tb_door_controller;

  logic clk = 1'b0;
  logic reset;
  logic tick, open_req, close_req, obstruct, moving;

  always #5 clk = ~clk;

  door_controller_if a_if ();
  door_controller_if b_if ();

  assign a_if.tick      = tick;
  assign a_if.open_req  = open_req;
  assign a_if.close_req = close_req;
  assign a_if.obstruct  = obstruct;
  assign a_if.moving    = moving;
  assign b_if.tick      = tick;
  assign b_if.open_req  = open_req;
  assign b_if.close_req = close_req;
  assign b_if.obstruct  = obstruct;
  assign b_if.moving    = moving;

  door_controller #(
    .OPEN_TICKS  (4),
    .HOLD_TICKS  (30),
    .CLOSE_TICKS (4)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .dbus  (a_if.slave)
  );

  door_controller #(
    .OPEN_TICKS  (1),
    .HOLD_TICKS  (1),
    .CLOSE_TICKS (1)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .dbus  (b_if.slave)
  );

  // Phase: 0 closed, 1 opening, 2 open, 3 closing; left = ticks still needed to end the phase.
  typedef struct {
    int phase;
    int left;
    bit opened;
    bit done;
  } mdl_t;

  mdl_t ma, mb;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.phase  = 0;
    m.left   = 0;
    m.opened = 1'b0;
    m.done   = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int no, int nh, int nc,
                                 bit t, bit op, bit cl, bit ob, bit mv);
    mdl_t n = m;
    n.opened = 1'b0;
    n.done   = 1'b0;
    case (m.phase)
      0: if (op && !mv) begin n.phase = 1; n.left = no; end
      1: if (t) begin
        if (m.left == 1) begin n.phase = 2; n.left = nh; n.opened = 1'b1; end
        else n.left = m.left - 1;
      end
      2: if (ob || op) n.left = nh;
         else if (cl) begin n.phase = 3; n.left = nc; end
         else if (t) begin
           if (m.left == 1) begin n.phase = 3; n.left = nc; end
           else n.left = m.left - 1;
         end
      default: if (ob || op) begin n.phase = 1; n.left = no; end
         else if (t) begin
           if (m.left == 1) begin n.phase = 0; n.left = 0; n.done = 1'b1; end
           else n.left = m.left - 1;
         end
    endcase
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".a.state"},  32'(a_if.door_state),  32'(ma.phase));
    chk({tag, ".a.closed"}, 32'(a_if.door_closed), 32'(ma.phase == 0));
    chk({tag, ".a.opened"}, 32'(a_if.opened),      32'(ma.opened));
    chk({tag, ".a.done"},   32'(a_if.done),        32'(ma.done));
    chk({tag, ".b.state"},  32'(b_if.door_state),  32'(mb.phase));
    chk({tag, ".b.closed"}, 32'(b_if.door_closed), 32'(mb.phase == 0));
    chk({tag, ".b.opened"}, 32'(b_if.opened),      32'(mb.opened));
    chk({tag, ".b.done"},   32'(b_if.done),        32'(mb.done));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input string tag, input bit t, input bit op, input bit cl,
                      input bit ob, input bit mv);
    tick = t; open_req = op; close_req = cl; obstruct = ob; moving = mv;
    @(posedge clk);
    ma = mstep(ma, 4, 30, 4, t, op, cl, ob, mv);
    mb = mstep(mb, 1, 1, 1, t, op, cl, ob, mv);
    cyc++;
    #1;
    cmp_all(tag);
    @(negedge clk);
  endtask

  // Tick every 10 clk with constant request levels.
  task automatic run(input string tag, input int n, input bit op, input bit cl,
                     input bit ob, input bit mv);
    for (int i = 0; i < n; i++) step(tag, (cyc % 10) == 0, op, cl, ob, mv);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    cmp_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick = 1'b0; open_req = 1'b0; close_req = 1'b0; obstruct = 1'b0; moving = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    @(negedge clk);
    cmp_all("por");
    reset = 1'b0;
    run("idle", 3, 0, 0, 0, 0);

    // Reset asserted mid-CLOSING.
    run("rc_req", 1, 1, 0, 0, 0);
    run("rc_open", 50, 0, 0, 0, 0);
    run("rc_close", 1, 0, 1, 0, 0);
    run("rc_closing", 12, 0, 0, 0, 0);
    chk("rc_in_closing", 32'(a_if.door_state), 32'd3);
    do_reset("rst_mid_closing");
    run("post_rst", 3, 0, 0, 0, 0);

    // Nominal full cycle.
    run("nom_req", 1, 1, 0, 0, 0);
    run("nom", 400, 0, 0, 0, 0);
    chk("nom_end", 32'(a_if.door_state), 32'd0);

    // Interlock.
    run("interlock", 20, 1, 0, 0, 1);
    chk("interlock_end", 32'(a_if.door_state), 32'd0);

    // Dwell restart after 20 ticks open.
    run("dw_req", 1, 1, 0, 0, 0);
    run("dw_open", 240, 0, 0, 0, 0);
    run("dw_restart", 1, 1, 0, 0, 0);
    run("dw_hold", 290, 0, 0, 0, 0);
    chk("dw_still_open", 32'(a_if.door_state), 32'd2);
    run("dw_close", 80, 0, 0, 0, 0);

    // Early close.
    run("ec_req", 1, 1, 0, 0, 0);
    run("ec_open", 50, 0, 0, 0, 0);
    run("ec_close", 1, 0, 1, 0, 0);
    chk("ec_closing", 32'(a_if.door_state), 32'd3);
    run("ec_done", 60, 0, 0, 0, 0);

    // Long obstruction in OPEN.
    run("ob_req", 1, 1, 0, 0, 0);
    run("ob_open", 50, 0, 0, 0, 0);
    run("ob_hold", 500, 0, 0, 1, 0);
    chk("ob_still_open", 32'(a_if.door_state), 32'd2);
    run("ob_release", 380, 0, 0, 0, 0);

    // Obstruction coincident with the 2nd tick of CLOSING, plus tick on entry.
    step("ent_tick", 1, 1, 0, 0, 0);
    run("oc_open", 60, 0, 0, 0, 0);
    step("oc_close", 0, 0, 1, 0, 0);
    step("oc_t1", 1, 0, 0, 0, 0);
    step("oc_t2_ob", 1, 0, 0, 1, 0);
    chk("oc_reopen", 32'(a_if.door_state), 32'd1);
    run("oc_reopened", 60, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset("rnd_rst");
      step("rnd", $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
